// File: rtl/aes128_key_schedule_ctrl.sv
// Iterative AES-128 key-schedule controller.
// One expansion step is reused for ten cycles. Round keys 0..10 are kept in
// an 11-entry register file, and the round engine reads them through an
// indexed port. READ_REG selects a combinational read or a 1-cycle registered read.
module aes128_key_schedule_ctrl #(
   parameter int READ_REG = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] key_in,
   input  logic         key_valid,
   output logic         key_ready,
   output logic         busy,
   output logic         keys_valid,
   output logic         done,
   input  logic [3:0]   rk_idx,
   output logic [127:0] rk_data
);

   typedef enum logic {IDLE, EXPAND} state_t;

   // Forward S-box. Byte 0 sits in the most significant position.
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   state_t       state;
   logic [3:0]   round;
   logic [127:0] work;
   logic [127:0] rk [0:10];
   logic [127:0] next_key;
   logic [127:0] rd_data;
   logic         accept;

   function automatic logic [7:0] aes_sbox(input logic [7:0] b);
      return SBOX[8 * (255 - int'(b)) +: 8];
   endfunction

   function automatic logic [7:0] rcon_of(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   // One key-expansion step: RotWord, SubWord, Rcon, then word chaining.
   function automatic logic [127:0] expand(input logic [127:0] w, input logic [7:0] rcon);
      logic [31:0] w0, w1, w2, w3, rot, t, n0, n1, n2, n3;
      w0  = w[127:96];
      w1  = w[95:64];
      w2  = w[63:32];
      w3  = w[31:0];
      rot = {w3[23:0], w3[31:24]};
      t   = {aes_sbox(rot[31:24]), aes_sbox(rot[23:16]),
             aes_sbox(rot[15:8]),  aes_sbox(rot[7:0])} ^ {rcon, 24'h0};
      n0  = w0 ^ t;
      n1  = w1 ^ n0;
      n2  = w2 ^ n1;
      n3  = w3 ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   assign key_ready = (state == IDLE) && !rst;
   assign accept    = key_valid && key_ready;
   assign next_key  = expand(work, rcon_of(round));

   // Control FSM: round counter and status flags, all registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         round      <= 4'd0;
         busy       <= 1'b0;
         keys_valid <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (key_valid) begin
                  state      <= EXPAND;
                  round      <= 4'd1;
                  busy       <= 1'b1;
                  keys_valid <= 1'b0;
               end
            end
            EXPAND: begin
               round <= round + 4'd1;
               if (round == 4'd10) begin
                  state      <= IDLE;
                  round      <= 4'd0;
                  busy       <= 1'b0;
                  keys_valid <= 1'b1;
                  done       <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Key storage and working key; contents are don't-care after reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         rk[0] <= key_in;
         work  <= key_in;
      end else if (state == EXPAND) begin
         rk[round] <= next_key;
         work      <= next_key;
      end
   end

   // Indexed read; out-of-range indices return zero.
   always_comb begin
      rd_data = '0;
      if (rk_idx <= 4'd10) rd_data = rk[rk_idx];
   end

   if (READ_REG != 0) begin : g_read_reg
      logic [127:0] rk_data_p1;

      // Registered read port: one cycle of latency, cleared on reset.
      always_ff @(posedge clk) begin
         if (rst) rk_data_p1 <= '0;
         else     rk_data_p1 <= rd_data;
      end

      assign rk_data = rk_data_p1;
   end else begin : g_read_comb
      assign rk_data = rd_data;
   end

endmodule

// File: tb/tb_aes128_key_schedule_ctrl.sv
// Directed and randomized checks for aes128_key_schedule_ctrl, using both read modes.
module tb_aes128_key_schedule_ctrl;

   localparam logic [127:0] FIPS_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_RK1   = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] FIPS_RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] ZERO_RK1   = 128'h62636363626363636263636362636363;
   localparam logic [127:0] ZERO_RK10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   logic         clk = 1'b0;
   logic         rst, key_valid;
   logic [127:0] key_in;
   logic [3:0]   rk_idx;
   logic         key_ready, busy, keys_valid, done;
   logic [127:0] rk_data;
   logic         key_ready_r, busy_r, keys_valid_r, done_r;
   logic [127:0] rk_data_r;

   int n_vec = 0;
   int n_err = 0;

   logic [127:0] exp_rk [11];

   logic [7:0] sbox_t [256] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
   };

   always #5 clk = ~clk;

   aes128_key_schedule_ctrl #(.READ_REG(0)) dut (
      .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid),
      .key_ready(key_ready), .busy(busy), .keys_valid(keys_valid), .done(done),
      .rk_idx(rk_idx), .rk_data(rk_data)
   );

   aes128_key_schedule_ctrl #(.READ_REG(1)) dut_r (
      .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid),
      .key_ready(key_ready_r), .busy(busy_r), .keys_valid(keys_valid_r), .done(done_r),
      .rk_idx(rk_idx), .rk_data(rk_data_r)
   );

   // Word-indexed FIPS-197 reference schedule written into exp_rk.
   task automatic compute_schedule(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] tmp;
      logic [7:0]  rc;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tmp = w[i - 1];
         if (i % 4 == 0) begin
            tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]}
                  ^ {rc, 24'h0};
            rc  = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
         end
         w[i] = w[i - 4] ^ tmp;
      end
      for (int k = 0; k < 11; k++) exp_rk[k] = {w[4 * k], w[4 * k + 1], w[4 * k + 2], w[4 * k + 3]};
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_key(input logic [127:0] k);
      key_in    = k;
      key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
   endtask

   // Returns the number of cycles until done, or 0 if it never came.
   task automatic wait_done(output int lat);
      lat = 0;
      for (int n = 1; n <= 30; n++) begin
         tick();
         if (done === 1'b1) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; key_valid = 1'b0; key_in = '0; rk_idx = 4'd0;
      tick();
      tick();
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b want 0", busy); end
      n_vec++; if (keys_valid !== 1'b0) begin n_err++; $display("FAIL reset_kv got %0b want 0", keys_valid); end
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %0b want 0", done); end
      n_vec++; if (key_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready_in_rst got %0b want 0", key_ready); end
      n_vec++; if (rk_data_r !== 128'h0) begin n_err++; $display("FAIL reset_rkdata_reg got %h want 0", rk_data_r); end
      rst = 1'b0;
      #1;
      n_vec++; if (key_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %0b want 1", key_ready); end
   endtask

   task automatic test_fips();
      int lat;
      start_key(FIPS_KEY);
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL fips_busy got %0b want 1", busy); end
      n_vec++; if (key_ready !== 1'b0) begin n_err++; $display("FAIL fips_ready_busy got %0b want 0", key_ready); end
      wait_done(lat);
      n_vec++; if (lat !== 10) begin n_err++; $display("FAIL fips_latency got %0d want 10", lat); end
      n_vec++; if (keys_valid !== 1'b1) begin n_err++; $display("FAIL fips_kv got %0b want 1", keys_valid); end
      n_vec++; if (key_ready !== 1'b1) begin n_err++; $display("FAIL fips_ready_done got %0b want 1", key_ready); end
      rk_idx = 4'd1; #1;
      n_vec++; if (rk_data !== FIPS_RK1) begin n_err++; $display("FAIL fips_rk1 got %h want %h", rk_data, FIPS_RK1); end
      rk_idx = 4'd10; #1;
      n_vec++; if (rk_data !== FIPS_RK10) begin n_err++; $display("FAIL fips_rk10 got %h want %h", rk_data, FIPS_RK10); end
      rk_idx = 4'd0; #1;
      n_vec++; if (rk_data !== FIPS_KEY) begin n_err++; $display("FAIL fips_rk0 got %h want %h", rk_data, FIPS_KEY); end
      tick();
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL fips_done_pulse got %0b want 0", done); end
      n_vec++; if (keys_valid !== 1'b1) begin n_err++; $display("FAIL fips_kv_hold got %0b want 1", keys_valid); end
   endtask

   task automatic test_zero_sweep();
      int lat;
      logic [127:0] expv, prev;
      compute_schedule(128'h0);
      start_key(128'h0);
      wait_done(lat);
      n_vec++; if (lat !== 10) begin n_err++; $display("FAIL zero_latency got %0d want 10", lat); end
      rk_idx = 4'd1; #1;
      n_vec++; if (rk_data !== ZERO_RK1) begin n_err++; $display("FAIL zero_rk1 got %h want %h", rk_data, ZERO_RK1); end
      rk_idx = 4'd10; #1;
      n_vec++; if (rk_data !== ZERO_RK10) begin n_err++; $display("FAIL zero_rk10 got %h want %h", rk_data, ZERO_RK10); end
      tick();
      prev = exp_rk[10];
      for (int i = 0; i < 16; i++) begin
         rk_idx = 4'(i);
         #1;
         expv = (i <= 10) ? exp_rk[i] : 128'h0;
         n_vec++; if (rk_data !== expv) begin n_err++; $display("FAIL sweep_comb idx=%0d got %h want %h", i, rk_data, expv); end
         n_vec++; if (rk_data_r !== prev) begin n_err++; $display("FAIL sweep_reg_lag idx=%0d got %h want %h", i, rk_data_r, prev); end
         tick();
         n_vec++; if (rk_data_r !== expv) begin n_err++; $display("FAIL sweep_reg idx=%0d got %h want %h", i, rk_data_r, expv); end
         prev = expv;
      end
   endtask

   task automatic test_hold_valid();
      int lat;
      key_in = 128'h0; key_valid = 1'b1;
      tick();
      for (int i = 1; i <= 10; i++) begin
         key_in = {$urandom, $urandom, $urandom, $urandom};
         tick();
         if (i < 10) begin
            n_vec++; if (key_ready !== 1'b0) begin n_err++; $display("FAIL hold_ready cyc=%0d got %0b want 0", i, key_ready); end
         end else begin
            n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL hold_done_a got %0b want 1", done); end
         end
      end
      key_in = FIPS_KEY;
      rk_idx = 4'd10; #1;
      n_vec++; if (rk_data !== ZERO_RK10) begin n_err++; $display("FAIL hold_rk10_a got %h want %h", rk_data, ZERO_RK10); end
      tick();
      key_valid = 1'b0;
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL hold_accept_b got %0b want 1", busy); end
      n_vec++; if (keys_valid !== 1'b0) begin n_err++; $display("FAIL hold_kv_b got %0b want 0", keys_valid); end
      wait_done(lat);
      n_vec++; if (lat !== 10) begin n_err++; $display("FAIL hold_latency_b got %0d want 10", lat); end
      #1;
      n_vec++; if (rk_data !== FIPS_RK10) begin n_err++; $display("FAIL hold_rk10_b got %h want %h", rk_data, FIPS_RK10); end
      rk_idx = 4'd0; #1;
      n_vec++; if (rk_data !== FIPS_KEY) begin n_err++; $display("FAIL hold_rk0_b got %h want %h", rk_data, FIPS_KEY); end
   endtask

   task automatic test_reset_mid();
      int lat;
      bit seen;
      start_key(FIPS_KEY);
      for (int i = 0; i < 4; i++) tick();
      rst = 1'b1;
      tick();
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy got %0b want 0", busy); end
      n_vec++; if (keys_valid !== 1'b0) begin n_err++; $display("FAIL mid_kv got %0b want 0", keys_valid); end
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL mid_done got %0b want 0", done); end
      rst = 1'b0;
      #1;
      n_vec++; if (key_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready got %0b want 1", key_ready); end
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (done === 1'b1 || keys_valid === 1'b1) seen = 1'b1;
      end
      n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL mid_no_done got %0b want 0", seen); end
      start_key(128'h0);
      wait_done(lat);
      n_vec++; if (lat !== 10) begin n_err++; $display("FAIL mid_latency got %0d want 10", lat); end
      rk_idx = 4'd10; #1;
      n_vec++; if (rk_data !== ZERO_RK10) begin n_err++; $display("FAIL mid_rk10 got %h want %h", rk_data, ZERO_RK10); end
   endtask

   task automatic test_back_to_back();
      int lat;
      start_key(FIPS_KEY);
      n_vec++; if (keys_valid !== 1'b0) begin n_err++; $display("FAIL b2b_kv_fall got %0b want 0", keys_valid); end
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL b2b_done_low got %0b want 0", done); end
      wait_done(lat);
      n_vec++; if (lat !== 10) begin n_err++; $display("FAIL b2b_latency got %0d want 10", lat); end
      n_vec++; if (keys_valid !== 1'b1) begin n_err++; $display("FAIL b2b_kv_rise got %0b want 1", keys_valid); end
      rk_idx = 4'd1; #1;
      n_vec++; if (rk_data !== FIPS_RK1) begin n_err++; $display("FAIL b2b_rk1 got %h want %h", rk_data, FIPS_RK1); end
      tick();
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL b2b_done_once got %0b want 0", done); end
   endtask

   task automatic test_random();
      int lat, gap;
      logic [127:0] k, expv;
      logic [3:0] idx;
      compute_schedule(FIPS_KEY);
      for (int it = 0; it < 1000; it++) begin
         gap = int'($urandom_range(0, 3));
         for (int g = 0; g < gap; g++) begin
            idx = 4'($urandom_range(0, 15));
            rk_idx = idx;
            #1;
            expv = (idx <= 4'd10) ? exp_rk[idx] : 128'h0;
            if (keys_valid === 1'b1) begin
               n_vec++; if (rk_data !== expv) begin n_err++; $display("FAIL rnd_gap it=%0d idx=%0d got %h want %h", it, idx, rk_data, expv); end
            end
            tick();
         end
         k = {$urandom, $urandom, $urandom, $urandom};
         compute_schedule(k);
         start_key(k);
         wait_done(lat);
         n_vec++; if (lat !== 10) begin n_err++; $display("FAIL rnd_latency it=%0d got %0d want 10", it, lat); end
         idx = 4'($urandom_range(0, 10));
         rk_idx = idx;
         #1;
         n_vec++; if (rk_data !== exp_rk[idx]) begin n_err++; $display("FAIL rnd_read it=%0d idx=%0d got %h want %h", it, idx, rk_data, exp_rk[idx]); end
      end
   endtask

   initial begin
      test_reset();
      test_fips();
      test_zero_sweep();
      test_hold_valid();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
